ped_out_merge: RTL and testbench
================================

# ped_out_merge

Downstream stage of `ped64`. It accepts the two result streams `ped64` produces:
- the leaf stream (`o_lvs`/`o_lvs_vld`/`o_last`);
- the final-result stream (`o_res`/`o_res_vld`).

It buffers each stream in a 2-entry skid FIFO and merges them into one tagged, framed output stream. Each frame is all leaf beats of one hash operation, then exactly one result beat. The block drives `ped64`'s `i_lvs_rdy`/`i_res_rdy`. It also reports per-beat indices, a completed-frame count and a sticky framing error.

## Interface
- FIELD_SIZE, 253, width of one field element.
- MAX_LVS, 16, maximum leaf beats per frame (1..255).
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_lvs_vld  in  1  leaf beat valid (from ped64 o_lvs_vld).
- i_lvs  in  FIELD_SIZE  leaf value.
- i_lvs_last  in  1  last leaf of operation, qualified by i_lvs_vld (from ped64 o_last).
- o_lvs_rdy  out  1  leaf FIFO can accept (to ped64 i_lvs_rdy).
- i_res_vld  in  1  result beat valid.
- i_res  in  FIELD_SIZE  result value.
- o_res_rdy  out  1  result FIFO can accept (to ped64 i_res_rdy).
- o_vld  out  1  merged output valid.
- o_data  out  FIELD_SIZE  merged output value.
- o_tag  out  1  0 = leaf beat, 1 = result beat.
- o_idx  out  8  beat index within frame.
- o_eop  out  1  end of frame; equals o_tag.
- i_rdy  in  1  downstream ready.
- o_frm_cnt  out  16  completed frames, wraps at 2^16.
- o_err  out  1  sticky leaf-overflow error.

## Operation
- **Leaf FIFO:** 2 entries, each {i_lvs, i_lvs_last}. Write on i_lvs_vld && o_lvs_rdy. o_lvs_rdy = (lvs_count != 2), decoded from the registered count.
- **Result FIFO:** same structure, holding i_res. Write on i_res_vld && o_res_rdy.
- **Output register:** {o_vld, o_data, o_tag, o_idx}. Loads when (!o_vld || i_rdy) and the selected FIFO is non-empty. That FIFO pops in the same cycle. When neither FIFO is selectable, an output handshake clears o_vld.
- **FSM states:**
  - S_LVS: selects the leaf FIFO. Each popped leaf increments beat_idx. Go to S_RES when the popped entry has last=1, or when beat_idx+1 == MAX_LVS (forced end).
  - S_RES: selects the result FIFO. Pop one entry, loaded with o_tag=1 and o_idx=beat_idx. Clear beat_idx and return to S_LVS.
- **Forced end:** the MAX_LVS-th leaf arrives without last=1. Set o_err (sticky until reset) and continue as if last=1. A later leaf with last=1 then opens a new frame; no realignment is attempted.
- **Frame count:** o_frm_cnt increments on the handshake o_vld && i_rdy && o_tag==1.
- **Ordering:**
  - A result arriving early is held in its FIFO. Once both entries are full, o_res_rdy=0 back-pressures ped64.
  - Leaves of the next frame may queue while the FSM is in S_RES.
- **Widths:** beat_idx is 8 bits; MAX_LVS ≤ 255 guarantees no wrap. No arithmetic is performed on data.

## Timing
- **Reset values:** o_vld=0, o_data=0, o_tag=0, o_idx=0, o_eop=0, o_frm_cnt=0, o_err=0, FSM=S_LVS, FIFOs empty. o_lvs_rdy=1 and o_res_rdy=1 from the first cycle after reset release.
- **Latency:** a beat accepted at edge k is visible on the outputs after edge k+1 when the output register is free.
- **Throughput:** 1 beat/cycle with i_rdy=1 continuously.
- **Handshakes:**
  - Outputs stay stable while o_vld && !i_rdy.
  - A FIFO may be written and popped in the same cycle; the count is unchanged.
  - When full, that same-cycle pop does not raise rdy in that cycle.
- **Mid-operation reset:** all state returns to the reset values, with no partial frame emitted. Buffered beats are discarded.
- **State transitions:** the S_LVS→S_RES and S_RES→S_LVS transitions occur on the same edge that loads the transitioning beat into the output register.

## Test plan
- **Single frame:** leaves A, B, C (C with last=1), then result R; i_rdy=1.
  - Required output: (A, tag0, idx0), (B, tag0, idx1), (C, tag0, idx2), (R, tag1, idx3, eop=1) on consecutive cycles.
  - Then o_frm_cnt=1.
- **Early result:** R arrives two cycles before the leaves, and a second R' arrives.
  - R is held until C is emitted.
  - o_res_rdy=0 after R' is accepted, until R pops.
- **Random backpressure:** i_rdy random 50%, ped64-like random valids, 100 frames of 1–5 leaves.
  - Output sequence matches the scoreboard exactly.
  - No beat is lost or duplicated while stalled.
  - o_frm_cnt=100.
- **Overflow:** MAX_LVS=4, six leaves with no last, then R.
  - Leaves 0–3 are emitted, then R with idx4.
  - o_err=1.
  - Leaves 4–5 start the next frame at idx0, idx1.
- **Mid-frame reset:** assert i_rst_n=0 after 2 of 3 leaves, then release.
  - All outputs are 0 and both rdy=1.
  - A fresh 1-leaf frame yields (L, idx0), (R, idx1), with o_frm_cnt=1.
- **Full FIFO simultaneous write/pop:** with i_rdy=1, o_lvs_rdy stays 0 for the cycle in which the full FIFO is both written and popped.

Source files
------------

// File: rtl/ped_out_merge.sv
// rtl/ped_out_merge.sv - merges ped64 leaf and result streams into tagged, framed output beats
// Two 2-entry skid FIFOs feed one output register; a two-state FSM frames leaves then one result.

module ped_out_merge_fifo #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_wr,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic         o_rdy,
    output logic         o_empty,
    output logic [W-1:0] o_rdata
);
    logic [W-1:0] mem [0:1];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         wr_en;

    // Ready comes only from the registered count, so a pop never raises it combinationally.
    assign o_rdy   = (count != 2'd2);
    assign o_empty = (count == 2'd0);
    assign o_rdata = mem[rd_ptr];
    assign wr_en   = i_wr && o_rdy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) wr_ptr <= ~wr_ptr;
            if (i_pop) rd_ptr <= ~rd_ptr;
            unique case ({wr_en, i_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr] <= i_wdata;
    end
endmodule

module ped_out_merge #(
    parameter int FIELD_SIZE = 253,
    parameter int MAX_LVS    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_lvs_vld,
    input  logic [FIELD_SIZE-1:0] i_lvs,
    input  logic                  i_lvs_last,
    output logic                  o_lvs_rdy,
    input  logic                  i_res_vld,
    input  logic [FIELD_SIZE-1:0] i_res,
    output logic                  o_res_rdy,
    output logic                  o_vld,
    output logic [FIELD_SIZE-1:0] o_data,
    output logic                  o_tag,
    output logic [7:0]            o_idx,
    output logic                  o_eop,
    input  logic                  i_rdy,
    output logic [15:0]           o_frm_cnt,
    output logic                  o_err
);
    typedef enum logic {S_LVS, S_RES} state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_LVS);

    state_t                state, state_nxt;
    logic [7:0]            beat_idx, beat_idx_nxt;
    logic                  pop_lvs, pop_res, err_set, out_free;
    logic                  lvs_empty, res_empty, lvs_last;
    logic [FIELD_SIZE-1:0] lvs_data, res_data;

    ped_out_merge_fifo #(.W(FIELD_SIZE + 1)) u_lvs_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_wr    (i_lvs_vld),
        .i_wdata ({i_lvs, i_lvs_last}),
        .i_pop   (pop_lvs),
        .o_rdy   (o_lvs_rdy),
        .o_empty (lvs_empty),
        .o_rdata ({lvs_data, lvs_last})
    );

    ped_out_merge_fifo #(.W(FIELD_SIZE)) u_res_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_wr    (i_res_vld),
        .i_wdata (i_res),
        .i_pop   (pop_res),
        .o_rdy   (o_res_rdy),
        .o_empty (res_empty),
        .o_rdata (res_data)
    );

    assign out_free = !o_vld || i_rdy;
    assign o_eop    = o_tag;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_LVS;
            beat_idx <= 8'd0;
        end else begin
            state    <= state_nxt;
            beat_idx <= beat_idx_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        beat_idx_nxt = beat_idx;
        pop_lvs      = 1'b0;
        pop_res      = 1'b0;
        err_set      = 1'b0;
        unique case (state)
            S_LVS: begin
                if (out_free && !lvs_empty) begin
                    pop_lvs      = 1'b1;
                    beat_idx_nxt = beat_idx + 8'd1;
                    // A frame that reaches MAX_LVS leaves is closed as if last had been seen.
                    if (lvs_last || (beat_idx + 8'd1 == MAX_CNT)) begin
                        state_nxt = S_RES;
                        err_set   = !lvs_last;
                    end
                end
            end
            S_RES: begin
                if (out_free && !res_empty) begin
                    pop_res      = 1'b1;
                    beat_idx_nxt = 8'd0;
                    state_nxt    = S_LVS;
                end
            end
            default: state_nxt = S_LVS;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_vld     <= 1'b0;
            o_data    <= '0;
            o_tag     <= 1'b0;
            o_idx     <= 8'd0;
            o_frm_cnt <= 16'd0;
            o_err     <= 1'b0;
        end else begin
            if (pop_lvs) begin
                o_vld  <= 1'b1;
                o_data <= lvs_data;
                o_tag  <= 1'b0;
                o_idx  <= beat_idx;
            end else if (pop_res) begin
                o_vld  <= 1'b1;
                o_data <= res_data;
                o_tag  <= 1'b1;
                o_idx  <= beat_idx;
            end else if (i_rdy) begin
                o_vld <= 1'b0;
            end
            if (o_vld && i_rdy && o_tag) o_frm_cnt <= o_frm_cnt + 16'd1;
            if (err_set) o_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ped_out_merge.sv
// tb/tb_ped_out_merge.sv - scoreboard bench for ped_out_merge with directed frames and backpressure

module tb_ped_out_merge;
    localparam int FS = 253;

    typedef struct {
        logic [FS-1:0] data;
        logic          tag;
        logic [7:0]    idx;
    } beat_t;

    typedef struct {
        logic [FS-1:0] d;
        logic          last;
    } lv_t;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_lvs_vld = 1'b0;
    logic [FS-1:0] i_lvs = '0;
    logic          i_lvs_last = 1'b0;
    logic          i_res_vld = 1'b0;
    logic [FS-1:0] i_res = '0;
    logic          i_rdy = 1'b0;

    logic          m_lvs_rdy, m_res_rdy, m_vld, m_tag, m_eop, m_err;
    logic [FS-1:0] m_data;
    logic [7:0]    m_idx;
    logic [15:0]   m_frm_cnt;
    logic          s_lvs_rdy, s_res_rdy, s_vld, s_tag, s_eop, s_err;
    logic [FS-1:0] s_data;
    logic [7:0]    s_idx;
    logic [15:0]   s_frm_cnt;

    logic          use_small = 1'b0;
    logic          rnd_rdy = 1'b0;
    logic          held = 1'b0;
    int            n_cmp = 0;
    int            n_fail = 0;
    int            cyc = 0;
    beat_t         sb[$];
    lv_t           lq[$];
    logic [FS-1:0] rq[$];
    int            hs_cyc[$];

    logic          sel_vld, sel_tag, sel_eop, lvs_rdy_sel;
    logic [FS-1:0] sel_data;
    logic [7:0]    sel_idx;

    assign sel_vld     = use_small ? s_vld : m_vld;
    assign sel_tag     = use_small ? s_tag : m_tag;
    assign sel_eop     = use_small ? s_eop : m_eop;
    assign sel_data    = use_small ? s_data : m_data;
    assign sel_idx     = use_small ? s_idx : m_idx;
    assign lvs_rdy_sel = use_small ? s_lvs_rdy : m_lvs_rdy;

    ped_out_merge #(.FIELD_SIZE(FS), .MAX_LVS(16)) u_main (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_lvs_vld(i_lvs_vld), .i_lvs(i_lvs), .i_lvs_last(i_lvs_last), .o_lvs_rdy(m_lvs_rdy),
        .i_res_vld(i_res_vld), .i_res(i_res), .o_res_rdy(m_res_rdy),
        .o_vld(m_vld), .o_data(m_data), .o_tag(m_tag), .o_idx(m_idx), .o_eop(m_eop),
        .i_rdy(i_rdy), .o_frm_cnt(m_frm_cnt), .o_err(m_err)
    );

    ped_out_merge #(.FIELD_SIZE(FS), .MAX_LVS(4)) u_small (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_lvs_vld(i_lvs_vld), .i_lvs(i_lvs), .i_lvs_last(i_lvs_last), .o_lvs_rdy(s_lvs_rdy),
        .i_res_vld(i_res_vld), .i_res(i_res), .o_res_rdy(s_res_rdy),
        .o_vld(s_vld), .o_data(s_data), .o_tag(s_tag), .o_idx(s_idx), .o_eop(s_eop),
        .i_rdy(i_rdy), .o_frm_cnt(s_frm_cnt), .o_err(s_err)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [FS-1:0] act, input logic [FS-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_beat(input logic [FS-1:0] d, input logic t, input logic [7:0] ix);
        beat_t b;
        b.data = d;
        b.tag  = t;
        b.idx  = ix;
        sb.push_back(b);
    endtask

    task automatic add_lvs(input logic [FS-1:0] d, input logic last);
        lv_t l;
        l.d    = d;
        l.last = last;
        lq.push_back(l);
    endtask

    task automatic send_lvs(input logic [FS-1:0] d, input logic last);
        bit acc;
        int t;
        acc = 0;
        t = 0;
        i_lvs = d;
        i_lvs_last = last;
        i_lvs_vld = 1'b1;
        while (!acc && t < 1000) begin
            @(negedge i_clk);
            acc = lvs_rdy_sel;
            @(posedge i_clk);
            #1;
            t++;
        end
        i_lvs_vld = 1'b0;
        i_lvs_last = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL lvs_timeout: leaf %0h not accepted, expected accept", d);
        end
    endtask

    task automatic send_res(input logic [FS-1:0] d);
        bit acc;
        int t;
        acc = 0;
        t = 0;
        i_res = d;
        i_res_vld = 1'b1;
        while (!acc && t < 1000) begin
            @(negedge i_clk);
            acc = use_small ? s_res_rdy : m_res_rdy;
            @(posedge i_clk);
            #1;
            t++;
        end
        i_res_vld = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL res_timeout: result %0h not accepted, expected accept", d);
        end
    endtask

    task automatic run_plan(input int maxgap);
        lv_t           lb;
        logic [FS-1:0] rb;
        fork
            while (lq.size() != 0) begin
                lb = lq.pop_front();
                repeat ($urandom_range(0, maxgap)) begin @(posedge i_clk); #1; end
                send_lvs(lb.d, lb.last);
            end
            while (rq.size() != 0) begin
                rb = rq.pop_front();
                repeat ($urandom_range(0, maxgap)) begin @(posedge i_clk); #1; end
                send_res(rb);
            end
        join
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 20000) begin
            @(negedge i_clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_lvs_vld = 1'b0;
        i_res_vld = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        sb.delete();
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks stall stability.
    initial begin
        beat_t         e;
        logic [FS-1:0] hd;
        logic [7:0]    hi;
        logic          ht;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk("stall_vld", FS'(sel_vld), FS'(1));
                    chk("stall_data", sel_data, hd);
                    chk("stall_tag", FS'(sel_tag), FS'(ht));
                    chk("stall_idx", FS'(sel_idx), FS'(hi));
                end
                held = sel_vld && !i_rdy;
                hd = sel_data;
                ht = sel_tag;
                hi = sel_idx;
                if (sel_vld && i_rdy) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got data %0h idx %0d, expected no beat", sel_data, sel_idx);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", sel_data, e.data);
                        chk("out_tag", FS'(sel_tag), FS'(e.tag));
                        chk("out_idx", FS'(sel_idx), FS'(e.idx));
                        chk("out_eop", FS'(sel_eop), FS'(e.tag));
                        hs_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (rnd_rdy) i_rdy = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        do_reset();
        @(negedge i_clk);
        chk("rst_vld", FS'(m_vld), FS'(0));
        chk("rst_data", m_data, FS'(0));
        chk("rst_tag", FS'(m_tag), FS'(0));
        chk("rst_idx", FS'(m_idx), FS'(0));
        chk("rst_eop", FS'(m_eop), FS'(0));
        chk("rst_frm_cnt", FS'(m_frm_cnt), FS'(0));
        chk("rst_err", FS'(m_err), FS'(0));
        chk("rst_lvs_rdy", FS'(m_lvs_rdy), FS'(1));
        chk("rst_res_rdy", FS'(m_res_rdy), FS'(1));
        @(posedge i_clk);
        #1;

        // Single frame A, B, C(last), R on consecutive output cycles
        i_rdy = 1'b1;
        hs_cyc.delete();
        exp_beat('h0A, 0, 0); exp_beat('h0B, 0, 1); exp_beat('h0C, 0, 2); exp_beat('hF1, 1, 3);
        add_lvs('h0A, 0); add_lvs('h0B, 0); add_lvs('h0C, 1); rq.push_back('hF1);
        run_plan(0);
        drain();
        chk("single_frm_cnt", FS'(m_frm_cnt), FS'(1));
        if (hs_cyc.size() == 4) chk("single_consecutive", FS'(hs_cyc[3] - hs_cyc[0]), FS'(3));
        else begin
            n_cmp++;
            n_fail++;
            $display("FAIL single_beats: got %0d beats expected 4", hs_cyc.size());
        end

        // Early result: R and R' queue ahead of the leaves and back-pressure ped64
        exp_beat('h21, 0, 0); exp_beat('h22, 0, 1); exp_beat('h23, 0, 2); exp_beat('h2F, 1, 3);
        exp_beat('h24, 0, 0); exp_beat('h3F, 1, 1);
        fork
            begin
                send_res('h2F);
                send_res('h3F);
                @(negedge i_clk);
                chk("early_res_rdy_full", FS'(m_res_rdy), FS'(0));
            end
            begin
                repeat (2) begin @(posedge i_clk); #1; end
                send_lvs('h21, 0); send_lvs('h22, 0); send_lvs('h23, 1); send_lvs('h24, 1);
            end
        join
        drain();
        chk("early_frm_cnt", FS'(m_frm_cnt), FS'(3));

        // Full leaf FIFO: ready stays low in the cycle it is popped
        i_rdy = 1'b0;
        exp_beat('h31, 0, 0); exp_beat('h32, 0, 1); exp_beat('h33, 0, 2); exp_beat('h34, 0, 3);
        exp_beat('h3E, 1, 4);
        fork
            begin
                send_lvs('h31, 0); send_lvs('h32, 0); send_lvs('h33, 0); send_lvs('h34, 1);
                send_res('h3E);
            end
            begin
                bit seen;
                int t;
                seen = 0;
                t = 0;
                while (!seen && t < 50) begin
                    @(negedge i_clk);
                    seen = !m_lvs_rdy;
                    t++;
                end
                chk("full_seen", FS'(seen), FS'(1));
                @(posedge i_clk);
                #1;
                i_rdy = 1'b1;
                @(negedge i_clk);
                chk("lvs_rdy_pop_full", FS'(m_lvs_rdy), FS'(0));
                @(negedge i_clk);
                chk("lvs_rdy_after_pop", FS'(m_lvs_rdy), FS'(1));
            end
        join
        drain();
        chk("full_frm_cnt", FS'(m_frm_cnt), FS'(4));

        // Random backpressure, 100 frames of 1..5 leaves
        do_reset();
        for (int f = 0; f < 100; f++) begin
            int n;
            n = $urandom_range(1, 5);
            for (int b = 0; b < n; b++) begin
                add_lvs(FS'(f * 256 + b + 1), b == n - 1);
                exp_beat(FS'(f * 256 + b + 1), 0, 8'(b));
            end
            rq.push_back(FS'(32'hF000_0000 + f));
            exp_beat(FS'(32'hF000_0000 + f), 1, 8'(n));
        end
        rnd_rdy = 1'b1;
        run_plan(2);
        drain();
        rnd_rdy = 1'b0;
        @(posedge i_clk);
        #1;
        i_rdy = 1'b1;
        chk("rand_frm_cnt", FS'(m_frm_cnt), FS'(100));
        chk("rand_err", FS'(m_err), FS'(0));

        // Overflow on the MAX_LVS=4 instance
        use_small = 1'b1;
        do_reset();
        exp_beat('h50, 0, 0); exp_beat('h51, 0, 1); exp_beat('h52, 0, 2); exp_beat('h53, 0, 3);
        exp_beat('h5F, 1, 4); exp_beat('h54, 0, 0); exp_beat('h55, 0, 1);
        for (int i = 0; i < 6; i++) add_lvs(FS'(8'h50 + i), 0);
        rq.push_back('h5F);
        run_plan(0);
        drain();
        chk("ovf_err", FS'(s_err), FS'(1));
        chk("ovf_frm_cnt", FS'(s_frm_cnt), FS'(1));

        // Mid-frame reset discards the partial frame
        use_small = 1'b0;
        do_reset();
        i_rdy = 1'b0;
        send_lvs('h61, 0);
        send_lvs('h62, 0);
        i_rst_n = 1'b0;
        #1;
        chk("mrst_vld", FS'(m_vld), FS'(0));
        chk("mrst_data", m_data, FS'(0));
        chk("mrst_tag", FS'(m_tag), FS'(0));
        chk("mrst_idx", FS'(m_idx), FS'(0));
        chk("mrst_eop", FS'(m_eop), FS'(0));
        chk("mrst_frm_cnt", FS'(m_frm_cnt), FS'(0));
        chk("mrst_err", FS'(m_err), FS'(0));
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        sb.delete();
        @(negedge i_clk);
        chk("mrst_lvs_rdy", FS'(m_lvs_rdy), FS'(1));
        chk("mrst_res_rdy", FS'(m_res_rdy), FS'(1));
        @(posedge i_clk);
        #1;
        i_rdy = 1'b1;
        exp_beat('h71, 0, 0); exp_beat('h7F, 1, 1);
        add_lvs('h71, 1);
        rq.push_back('h7F);
        run_plan(0);
        drain();
        chk("mrst_frm_cnt_after", FS'(m_frm_cnt), FS'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
